seq_multiplier: RTL and testbench

//  Parametrised iterative shift-add multiplier with signed/unsigned mode select and start/busy/finished handshake.

---
 rtl/seq_multiplier.sv | 135 +++++++++++++
 tb/tb_seq_multiplier.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per cycle, signed/unsigned operands.
// Optional MUL_EARLY_TERM_EN: stop iterating once the remaining multiplier bits are all zero.
module seq_multiplier #(
    parameter int BITS = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic [BITS-1:0]   i_multiplicand,
    input  logic [BITS-1:0]   i_multiplier,
    output logic              o_busy,
    output logic              o_finished,
    output logic [2*BITS-1:0] o_product
);

    localparam int PW = 2 * BITS;
    localparam int CW = $clog2(BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [BITS-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic            neg_q, neg_d;
    logic            busy_q, busy_d;
    logic            finished_q, finished_d;
    logic [PW-1:0]   product_q, product_d;

    // Magnitude of an operand; -2^(BITS-1) maps to 2^(BITS-1), which still fits unsigned.
    function automatic logic [BITS-1:0] magnitude(input logic [BITS-1:0] v, input logic sgn);
        logic [BITS-1:0] m;
        if (sgn && v[BITS-1]) begin
            m = (~v) + BITS'(1);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        count_d    = count_q;
        neg_d      = neg_q;
        busy_d     = 1'b0;
        finished_d = 1'b0;
        product_d  = product_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    mcand_d  = {{BITS{1'b0}}, magnitude(i_multiplicand, i_signed)};
                    mplier_d = magnitude(i_multiplier, i_signed);
                    neg_d    = i_signed & (i_multiplicand[BITS-1] ^ i_multiplier[BITS-1]);
                    acc_d    = '0;
                    count_d  = CW'(BITS);
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = acc_q + (mcand_q & {PW{mplier_q[0]}});
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
`ifdef MUL_EARLY_TERM_EN
                if ((count_q == CW'(1)) || ((mplier_q >> 1) == '0)) begin
`else
                if (count_q == CW'(1)) begin
`endif
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // Magnitude product never reaches 2^(2*BITS), so the negate is exact.
                if (neg_q) begin
                    product_d = (~acc_q) + PW'(1);
                end else begin
                    product_d = acc_q;
                end
                finished_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            neg_q      <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            product_q  <= '0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            neg_q      <= neg_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            product_q  <= product_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_finished = finished_q;
    assign o_product  = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (BITS=8): driver pushes expected product and latency,
// an independent monitor pops and compares on every o_finished.
module tb_seq_multiplier;

    localparam int BITS = 8;
    localparam int PW   = 2 * BITS;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            sgn;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            busy;
    logic            fin;
    logic [PW-1:0]   prod;

    seq_multiplier #(.BITS(BITS)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_signed       (sgn),
        .i_multiplicand (a),
        .i_multiplier   (b),
        .o_busy         (busy),
        .o_finished     (fin),
        .o_product      (prod)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] prod;
        int            acc_cyc;
        int            lat;
        string         name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [PW-1:0] ref_mul(input logic [BITS-1:0] x, input logic [BITS-1:0] y,
                                              input logic s);
        longint px, py;
        if (s) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end else begin
            px = longint'(x);
            py = longint'(y);
        end
        return PW'(px * py);
    endfunction

    // Edges from acceptance to o_finished.
    function automatic int ref_lat(input logic [BITS-1:0] y, input logic s);
`ifdef MUL_EARLY_TERM_EN
        int mag;
        int k;
        mag = (s && y[BITS-1]) ? -int'($signed(y)) : int'(y);
        k = 1;
        for (int i = 0; i < BITS; i++) if (((mag >> i) & 1) == 1) k = i + 1;
        return k + 1;
`else
        return BITS + 1;
`endif
    endfunction

    // Monitor: every finished pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (fin) begin
            if (sbq.size() == 0) begin
                check("unexpected_finish", 1, 0);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_product"}, prod, e.prod);
                check({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [BITS-1:0] x, input logic [BITS-1:0] y, input logic s,
                        input logic [PW-1:0] ep, input string name);
        exp_t e;
        start = 1'b1; a = x; b = y; sgn = s;
        @(negedge clk);
        e.prod = ep; e.acc_cyc = cyc; e.lat = ref_lat(y, s); e.name = name;
        sbq.push_back(e);
        start = 1'b0;
        a = BITS'($urandom); b = BITS'($urandom); sgn = 1'($urandom);
    endtask

    // Waits (bounded) for the finished pulse, counting busy cycles on the way.
    task automatic wait_done(output int busy_cnt);
        bit seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (fin) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        if (!seen) begin
            check("finish_timeout", 0, 1);
            sbq.delete();
        end
    endtask

    int             bc;
    int             nfin;
    logic [BITS-1:0] ra, rb;
    logic            rs;

    initial begin
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_finished", fin, 0);
        check("reset_product", prod, 0);
        rst = 1'b0;
        @(negedge clk);

        send(8'd13, 8'd11, 1'b0, 16'h008F, "u13x11");
        wait_done(bc);
        check("u13x11_busy_cycles", bc, ref_lat(8'd11, 1'b0) - 1);
        @(negedge clk);

        send(8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255"); wait_done(bc);
        send(8'hFD, 8'd5, 1'b1, 16'hFFF1, "s-3x5");       wait_done(bc);
        send(8'h80, 8'h80, 1'b1, 16'h4000, "s-128x-128"); wait_done(bc);
        send(8'h80, 8'h7F, 1'b1, 16'hC080, "s-128x127");  wait_done(bc);

        // start during RUN must be ignored
        send(8'd20, 8'd30, 1'b0, 16'd600, "ign_run");
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'd77; b = 8'd99; sgn = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        repeat (12) @(negedge clk);

        // start during DONE (busy already low, finish not yet shown) must be ignored
        send(8'd9, 8'd9, 1'b0, 16'd81, "ign_done");
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("done_cycle_no_finish", fin, 0);
        start = 1'b1; a = 8'd5; b = 8'd5; sgn = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("done_then_finish", fin, 1);
        repeat (14) @(negedge clk);

        // back-to-back: start in the finished cycle
        send(8'd13, 8'd11, 1'b0, 16'h008F, "b2b_first");
        wait_done(bc);
        send(8'd6, 8'd7, 1'b0, 16'h002A, "b2b_second");
        wait_done(bc);
        @(negedge clk);

        // reset mid-RUN discards the operation
        send(8'd200, 8'd3, 1'b0, 16'd600, "rst_run");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sbq.pop_back());
        check("rst_run_busy", busy, 0);
        check("rst_run_product", prod, 0);
        nfin = 0;
        for (int i = 0; i < 12; i++) begin
            if (fin) nfin++;
            @(negedge clk);
        end
        check("rst_run_no_finish", nfin, 0);
        send(8'd6, 8'd7, 1'b0, 16'h002A, "fresh6x7"); wait_done(bc);

        send(8'd100, 8'd1, 1'b0, 16'h0064, "u100x1"); wait_done(bc);
        send(8'd1, 8'd0, 1'b0, 16'h0000, "u1x0");     wait_done(bc);
        send(8'd1, 8'd128, 1'b0, 16'h0080, "u1x128"); wait_done(bc);
        @(negedge clk);

        for (int n = 0; n < 600; n++) begin
            ra = BITS'($urandom);
            rb = BITS'($urandom);
            rs = 1'($urandom);
            if ($urandom_range(7, 0) == 0) ra = 8'h80;
            if ($urandom_range(7, 0) == 0) rb = (n % 2 == 0) ? 8'h80 : 8'hFF;
            if ($urandom_range(15, 0) == 0) rb = 8'h00;
            send(ra, rb, rs, ref_mul(ra, rb, rs), rs ? "rand_signed" : "rand_unsigned");
            wait_done(bc);
            if ($urandom_range(1, 0) == 1) repeat ($urandom_range(2, 1)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
